// File: rtl/obc_shift_accumulator.sv
// obc_shift_accumulator
// Bit-serial OBC DFT controller/accumulator. Presents one bit of each of the
// eight input samples per cycle (LSB first) as ROM address bits, sums the four
// returned ROM partial words and shift-accumulates them into one output term.
// Optional build macro: OBC_SHIFT_ROUND_EN -- round half-up on every shift step
// instead of truncating (the sign-bit subtract step is the same in both builds).
module obc_shift_accumulator #(
  parameter int W     = 8,
  parameter int ACC_W = 34
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*W-1:0]     in_samples,
  input  logic [31:0]        init_val,
  output logic [7:0]         x_bits,
  input  logic [31:0]        rom_word0,
  input  logic [31:0]        rom_word1,
  input  logic [31:0]        rom_word2,
  input  logic [31:0]        rom_word3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [8*W-1:0]     sr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [7:0]         x_bits_q;
  logic [ACC_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [ACC_W-1:0]   rom_sum;
  logic [ACC_W-1:0]   acc_step;
  logic [ACC_W-1:0]   acc_shr;
  logic [ACC_W-1:0]   acc_sign;
  logic [ACC_W-1:0]   init_ext;
  logic               round_bit;
  logic [8*W-1:0]     sr_load;
  logic [8*W-1:0]     sr_next;
  logic [7:0]         x_load;
  logic [7:0]         x_next;

  // Accumulator datapath: ROM word sum, shift step and sign-bit subtract step
  always_comb begin
`ifdef OBC_SHIFT_ROUND_EN
    round_bit = 1'b1;
`else
    round_bit = 1'b0;
`endif
    rom_sum  = {{(ACC_W-32){rom_word0[31]}}, rom_word0}
             + {{(ACC_W-32){rom_word1[31]}}, rom_word1}
             + {{(ACC_W-32){rom_word2[31]}}, rom_word2}
             + {{(ACC_W-32){rom_word3[31]}}, rom_word3};
    acc_step = acc_q + rom_sum + {{(ACC_W-1){1'b0}}, round_bit};
    acc_shr  = $signed(acc_step) >>> 1;
    acc_sign = acc_q - rom_sum;
    init_ext = {{(ACC_W-32){init_val[31]}}, init_val};
  end

  // Bit-slice shifter: x_bits is registered one step ahead, so the shift
  // register always holds the samples already advanced past the bit on x_bits.
  always_comb begin
    sr_load = '0;
    sr_next = '0;
    x_load  = '0;
    x_next  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      x_load[k]             = in_samples[k*W];
      sr_load[k*W +: W]     = in_samples[k*W +: W] >> 1;
      x_next[k]             = sr_q[k*W];
      sr_next[k*W +: W]     = sr_q[k*W +: W] >> 1;
    end
  end

  // Control FSM with registered handshake outputs, ROM address bits and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      acc_q       <= '0;
      x_bits_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          x_bits_q   <= '0;
          if (in_valid) begin
            sr_q       <= sr_load;
            x_bits_q   <= x_load;
            acc_q      <= init_ext;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == LAST_BIT) begin
            acc_q       <= acc_sign;
            out_data_q  <= acc_sign;
            out_valid_q <= 1'b1;
            x_bits_q    <= '0;
            cnt_q       <= '0;
            state_q     <= HOLD;
          end else begin
            acc_q    <= acc_shr;
            cnt_q    <= cnt_q + 1'b1;
            sr_q     <= sr_next;
            x_bits_q <= x_next;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign x_bits    = x_bits_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Testbench for obc_shift_accumulator: directed scenarios plus randomized
// vectors against a ROM stub and an arithmetic reference model.
module tb_obc_shift_accumulator;

  localparam int W     = 8;
  localparam int ACC_W = 34;
`ifdef OBC_SHIFT_ROUND_EN
  localparam longint RND = 1;
`else
  localparam longint RND = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8*W-1:0]   in_samples = '0;
  logic [31:0]      init_val = '0;
  logic [7:0]       x_bits;
  logic [31:0]      rom_word0, rom_word1, rom_word2, rom_word3;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  logic             dir_ready = 1'b1;
  logic             rand_rdy = 1'b0;
  logic             rnd_bit = 1'b1;
  int               rom_mode = 0;
  logic [31:0]      rom_tbl [4][256];

  int errors = 0;
  int checks = 0;

  // model state
  bit               m_busy = 1'b0;
  int               cyc = 0;
  int               m_cap = 0;
  logic [8*W-1:0]   m_smp = '0;
  logic [ACC_W-1:0] m_res = '0;
  logic [ACC_W-1:0] m_last = '0;
  bit               done = 1'b0;

  assign out_ready = rand_rdy ? rnd_bit : dir_ready;

  obc_shift_accumulator #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_samples(in_samples), .init_val(init_val),
    .x_bits(x_bits),
    .rom_word0(rom_word0), .rom_word1(rom_word1),
    .rom_word2(rom_word2), .rom_word3(rom_word3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input int r, input logic [7:0] x);
    case (rom_mode)
      0:       return 32'h0000_1000;
      1:       return 32'h0000_0000;
      default: return rom_tbl[r][x];
    endcase
  endfunction

  assign rom_word0 = rom_val(0, x_bits);
  assign rom_word1 = rom_val(1, x_bits);
  assign rom_word2 = rom_val(2, x_bits);
  assign rom_word3 = rom_val(3, x_bits);

  // Result from the formula: add-and-halve for magnitude bits, subtract for the sign bit
  function automatic logic [ACC_W-1:0] model_res(input logic [8*W-1:0] smp,
                                                 input logic [31:0] iv);
    longint acc, s;
    logic [7:0] xv;
    logic [ACC_W-1:0] t;
    acc = longint'($signed(iv));
    for (int j = 0; j < W; j++) begin
      for (int k = 0; k < 8; k++) xv[k] = smp[k*W + j];
      s = 0;
      for (int r = 0; r < 4; r++) s += longint'($signed(rom_val(r, xv)));
      if (j < W - 1) begin
        t   = ACC_W'(acc + s + RND);
        acc = longint'($signed(t)) >>> 1;
      end else begin
        t   = ACC_W'(acc - s);
        acc = longint'($signed(t));
      end
    end
    return ACC_W'(acc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [8*W-1:0] smp, input logic [31:0] iv);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("send_timeout", 64'(in_ready), 64'd1);
    in_samples = smp;
    init_val   = iv;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  function automatic logic [8*W-1:0] rand_smp();
    logic [8*W-1:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  initial begin
    logic [7:0] xh [W+1];
    int lat;

    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 256; a++) rom_tbl[r][a] = $urandom;

    // Model pins: hand-computed results from the constant-ROM and offset-only cases
    rom_mode = 0;
    chk("model_const", 64'(model_res(rand_smp(), 32'h0)), 64'h3_FFFF_FF80);
    rom_mode = 1;
    chk("model_offset", 64'(model_res(rand_smp(), 32'h0000_8000)), 64'h0_0000_0100);

    // Cycle-by-cycle compare against the model
    fork
      begin
        while (!done) begin
          logic [7:0] ex;
          logic [ACC_W-1:0] ed;
          bit ev;
          @(posedge clk);
          cyc++;
          if (rst) begin
            m_busy = 1'b0;
            m_last = '0;
          end else if (!m_busy) begin
            if (in_valid) begin
              m_busy = 1'b1;
              m_cap  = cyc;
              m_smp  = in_samples;
              m_res  = model_res(in_samples, init_val);
            end
          end else if ((cyc - 1 - m_cap) >= W && out_ready) begin
            m_busy = 1'b0;
            m_last = m_res;
          end
          @(negedge clk);
          if (rand_rdy) rnd_bit = ($urandom_range(0, 3) != 0);
          ev = m_busy && (cyc - m_cap >= W);
          ex = '0;
          if (m_busy && (cyc - m_cap < W))
            for (int k = 0; k < 8; k++) ex[k] = m_smp[k*W + (cyc - m_cap)];
          ed = ev ? m_res : m_last;
          chk("in_ready",  64'(in_ready),  64'(!m_busy));
          chk("out_valid", 64'(out_valid), 64'(ev));
          chk("x_bits",    64'(x_bits),    64'(ex));
          chk("out_data",  64'(out_data),  64'(ed));
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Constant ROM: latency and literal result
    rom_mode = 0;
    send(rand_smp(), 32'h0);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'(W + 1));
    chk("const_result", 64'(out_data), 64'h3_FFFF_FF80);
    wait_idle();

    // Offset only
    rom_mode = 1;
    send(rand_smp(), 32'h0000_8000);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("offset_result", 64'(out_data), 64'h0_0000_0100);
    wait_idle();

    // Bit ordering
    rom_mode = 2;
    send({8'h80, 48'h0, 8'h01}, 32'h1234_5678);
    for (int i = 0; i <= W; i++) begin
      xh[i] = x_bits;
      @(posedge clk); #1;
    end
    chk("xbits_cyc0", 64'(xh[0]), 64'h01);
    for (int i = 1; i < W - 1; i++) chk("xbits_mid", 64'(xh[i]), 64'h00);
    chk("xbits_cyc7", 64'(xh[W-1]), 64'h80);
    chk("xbits_hold", 64'(xh[W]), 64'h00);
    wait_idle();

    // Backpressure
    dir_ready = 1'b0;
    send(rand_smp(), $urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("bp_valid_held", 64'(out_valid), 64'd1);
    chk("bp_in_ready",   64'(in_ready),  64'd0);
    dir_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_ready_back", 64'(in_ready),  64'd1);

    // Busy ignore: second vector pulsed mid-pass must not be taken
    send(rand_smp(), $urandom);
    repeat (2) @(posedge clk);
    in_samples = rand_smp();
    init_val   = $urandom;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    wait_idle();
    send(in_samples, init_val);
    wait_idle();

    // Reset mid-pass at SHIFT cycle 3
    send(rand_smp(), $urandom);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_x_bits",    64'(x_bits),    64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    send(rand_smp(), $urandom);
    wait_idle();

    // Randomized vectors with random backpressure and gaps
    rand_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      send(rand_smp(), $urandom);
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    wait_idle();

    repeat (3) @(posedge clk);
    done = 1'b1;
    @(posedge clk); @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obc_shift_accumulator.md
Name: obc_shift_accumulator

Overview:
- Bit-serial controller and accumulator that reads the OBC DFT partial-sum ROMs.
- Accepts eight W-bit two's-complement input samples in parallel and presents one bit of each sample per cycle (LSB first) on the ROM address bits x0..x7.
- Receives the four 32-bit ROM partial words (Q11.21), sums them and shift-accumulates into one OBC DFT output term.
- One instance per real/imag ROM group per DFT bin.

Parameters:
- W, 8, input sample width in bits (two's complement); one OBC pass = W cycles.
- ACC_W, 34, accumulator/result width (32-bit ROM word + 2 bits for the 4-word sum).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample vector valid.
- in_ready  out  1  block can accept a vector.
- in_samples  in  8*W  sample k at bits [k*W +: W], k=0..7.
- init_val  in  32  OBC offset word (Q11.21), sampled with the vector.
- x_bits  out  8  ROM address bits; x_bits[k] drives ROM input xk.
- rom_word0..rom_word3  in  32 each  ROM partial words out0..out3 (combinational return, same cycle).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  accumulated result, Q(ACC_W-21).21 two's complement.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, x_bits=0, bit counter=0, accumulator=0, shift register=0.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_samples into an 8×W shift register, load acc = sign-extended init_val, cnt=0, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - x_bits[k] = bit cnt of sample k, registered so it is valid the cycle cnt is used.
  - S = sign-extended sum of rom_word0..3 (ACC_W bits).
  - For cnt=0..W-2: acc <= (acc + S) >>> 1, arithmetic shift, truncating.
  - For cnt=W-1 (sign bit): acc <= acc - S, no shift. Then load out_data, assert out_valid, go to HOLD.
  - x_bits return to 0 outside SHIFT.
- HOLD:
  - out_valid=1 and out_data stable until out_valid&&out_ready.
  - On that handshake: out_valid=0 next cycle, return to IDLE.
- Latency: first sample-capture edge to out_valid = W+1 cycles. Throughput: one vector per W+2 cycles minimum.
- in_valid while not in IDLE: ignored (in_ready=0); the source must hold data.
- Arithmetic: all add/sub in ACC_W bits, two's complement wrap on overflow, no saturation.
- Result = -S(W-1) + Σ_{j<W-1} S(j)·2^-(W-1-j) + init_val·2^-(W-1), with truncation after each shift.
- rst in any state: next cycle matches reset values; any partial pass is discarded and no out_valid is produced.
- rst has priority over in_valid and out_ready in the same cycle.

Optional Feature:
- Macro OBC_SHIFT_ROUND_EN.
- Defined: each SHIFT-step shift rounds half-up: acc <= (acc + S + 1) >>> 1.
- Undefined: truncating shift as above.
- Sign-bit step is identical in both builds.
- Test values below assume the macro is undefined.

Test Plan:
- Constant ROM: stub returns 32'h0000_1000 on all four words (S=0x4000), init_val=0, any samples -> acc sequence 0x2000, 0x3000, 0x3800, 0x3C00, 0x3E00, 0x3F00, 0x3F80; out_data=34'h3_FFFF_FF80, out_valid rises 9 cycles after capture.
- Offset only: ROM stub returns 0, init_val=32'h0000_8000 -> out_data=34'h0_0000_0100.
- Bit ordering: sample0=8'h01, sample7=8'h80, others 0 -> x_bits[0]=1 only in SHIFT cycle 0; x_bits[7]=1 only in cycle 7; all other x_bits 0 throughout.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Busy ignore: in_valid pulsed with a different vector during SHIFT -> result matches only the first vector; second vector accepted only once in_ready=1.
- Reset mid-pass: rst high at SHIFT cycle 3 -> next cycle in_ready=1, out_valid=0, x_bits=0, out_data=0; a new vector then gives the correct, uncontaminated result.
